// File: rtl/genesis_pad_reader_pkg.sv
// Shared definitions for the Genesis pad reader.
// Button indices follow the bit map the world module consumes on
// control_inputs. The scan state enum covers the idle wait plus the
// eight select half-phases of one pad read.
package genesis_pad_reader_pkg;

    localparam int NUM_BTNS  = 12;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_A     = 4;
    localparam int BTN_B     = 5;
    localparam int BTN_C     = 6;
    localparam int BTN_X     = 7;
    localparam int BTN_Y     = 8;
    localparam int BTN_Z     = 9;
    localparam int BTN_START = 10;
    localparam int BTN_MODE  = 11;

    typedef enum logic [3:0] {
        IDLE, P1, P2, P3, P4, P5, P6, P7, P8
    } scan_state_t;

endpackage

// File: rtl/genesis_pad_reader_debounce.sv
// Per-bit scan debouncer with press-pulse generation.
// Ports:
//   clock_50    in   system clock
//   reset_flag  in   asynchronous, active-high reset
//   raw         in   WIDTH  raw button vector from the last scan
//   strobe      in   1      one-cycle pulse when raw is fresh
//   held        out  WIDTH  debounced level, 1 = pressed
//   press_pulse out  WIDTH  one-cycle pulse on each committed 0->1
module genesis_pad_reader_debounce
    import genesis_pad_reader_pkg::*;
#(
    parameter int WIDTH          = NUM_BTNS,
    parameter int DEBOUNCE_POLLS = 2
) (
    input  logic             clock_50,
    input  logic             reset_flag,
    input  logic [WIDTH-1:0] raw,
    input  logic             strobe,
    output logic [WIDTH-1:0] held,
    output logic [WIDTH-1:0] press_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_POLLS + 1);
    // Counter value at which the next differing scan commits the bit.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_POLLS - 1);

    logic [CNT_W-1:0] r_cnt [WIDTH];
    logic [WIDTH-1:0] r_held;
    logic [WIDTH-1:0] r_pulse;

    always_ff @(posedge clock_50 or posedge reset_flag) begin
        if (reset_flag) begin
            for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
            r_held  <= '0;
            r_pulse <= '0;
        end else begin
            r_pulse <= '0;
            if (strobe) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (raw[i] != r_held[i]) begin
                        if (r_cnt[i] == CNT_LAST) begin
                            r_held[i]  <= raw[i];
                            r_pulse[i] <= raw[i];
                            r_cnt[i]   <= '0;
                        end else begin
                            r_cnt[i] <= r_cnt[i] + 1'b1;
                        end
                    end else begin
                        // Any agreeing scan restarts the run of differing scans.
                        r_cnt[i] <= '0;
                    end
                end
            end
        end
    end

    assign held        = r_held;
    assign press_pulse = r_pulse;

endmodule

// File: rtl/genesis_pad_reader.sv
// Sega Genesis / Mega Drive 3- or 6-button pad scanner.
// Once per poll period it walks the select line through eight half-phases,
// samples the pad pins at the end of each, assembles a 12-bit button vector
// and hands it to the debouncer, which produces held levels and press pulses.
// Ports:
//   clock_50        in   system clock
//   reset_flag      in   asynchronous, active-high reset
//   pad_data        in   6   raw pad pins, active-low
//   pad_select      out  1   pad select line
//   control_inputs  out  12  one-cycle press pulses
//   buttons_held    out  12  debounced levels, 1 = pressed
//   six_button      out  1   last scan saw a 6-button pad
//   scan_done       out  1   one-cycle pulse at the end of each scan
//
// state | meaning
// IDLE  | waiting for poll counter wrap, select high
// P1    | select low: presence check, capture A / Start
// P2    | select high: capture Up/Down/Left/Right/B/C
// P3    | select low: no capture
// P4    | select high: no capture
// P5    | select low: 6-button detect (d[3:0] all low)
// P6    | select high: capture Z/Y/X/Mode if 6-button
// P7    | select low: no capture
// P8    | select high: publish vector, pulse scan_done
module genesis_pad_reader
    import genesis_pad_reader_pkg::*;
#(
    parameter int POLL_DIV       = 833333,
    parameter int STEP_CYCLES    = 500,
    parameter int DEBOUNCE_POLLS = 2
) (
    input  logic                clock_50,
    input  logic                reset_flag,
    input  logic [5:0]          pad_data,
    output logic                pad_select,
    output logic [NUM_BTNS-1:0] control_inputs,
    output logic [NUM_BTNS-1:0] buttons_held,
    output logic                six_button,
    output logic                scan_done
);

    localparam int POLL_W = $clog2(POLL_DIV);
    localparam int STEP_W = $clog2(STEP_CYCLES);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_DIV - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

    logic [5:0]          r_sync1;
    logic [5:0]          r_sync2;
    logic [POLL_W-1:0]   r_poll;
    logic [STEP_W-1:0]   r_step;
    scan_state_t         r_state;
    logic                r_select;
    logic [NUM_BTNS-1:0] r_raw;
    logic                r_present;
    logic                r_six_flag;
    logic [NUM_BTNS-1:0] r_raw_done;
    logic                r_six_button;
    logic                r_scan_done;

    logic [5:0]          w_d;
    logic                w_poll_wrap;
    logic                w_step_end;
    logic [NUM_BTNS-1:0] w_raw_final;
    logic [NUM_BTNS-1:0] w_held;
    logic [NUM_BTNS-1:0] w_press;

    // Pins idle high (released) out of reset.
    always_ff @(posedge clock_50 or posedge reset_flag) begin
        if (reset_flag) begin
            r_sync1 <= 6'h3F;
            r_sync2 <= 6'h3F;
        end else begin
            r_sync1 <= pad_data;
            r_sync2 <= r_sync1;
        end
    end

    assign w_d         = ~r_sync2;
    assign w_poll_wrap = (r_poll == POLL_LAST);
    assign w_step_end  = (r_step == '0);

    // Free-running so scan length never stretches the poll period.
    always_ff @(posedge clock_50 or posedge reset_flag) begin
        if (reset_flag)       r_poll <= '0;
        else if (w_poll_wrap) r_poll <= '0;
        else                  r_poll <= r_poll + 1'b1;
    end

    always_comb begin
        w_raw_final = r_raw;
        if (!r_six_flag) begin
            w_raw_final[BTN_X]    = 1'b0;
            w_raw_final[BTN_Y]    = 1'b0;
            w_raw_final[BTN_Z]    = 1'b0;
            w_raw_final[BTN_MODE] = 1'b0;
        end
        if (!r_present) w_raw_final = '0;
    end

    always_ff @(posedge clock_50 or posedge reset_flag) begin
        if (reset_flag) begin
            r_state      <= IDLE;
            r_step       <= '0;
            r_select     <= 1'b1;
            r_raw        <= '0;
            r_present    <= 1'b0;
            r_six_flag   <= 1'b0;
            r_raw_done   <= '0;
            r_six_button <= 1'b0;
            r_scan_done  <= 1'b0;
        end else begin
            r_scan_done <= 1'b0;
            if (r_state == IDLE) begin
                if (w_poll_wrap) begin
                    r_state    <= P1;
                    r_step     <= STEP_LAST;
                    r_select   <= 1'b0;
                    r_raw      <= '0;
                    r_present  <= 1'b0;
                    r_six_flag <= 1'b0;
                end
            end else if (!w_step_end) begin
                r_step <= r_step - 1'b1;
            end else begin
                // Last clock of the phase: sample before select moves.
                case (r_state)
                    P1: begin
                        r_present        <= w_d[2] & w_d[3];
                        r_raw[BTN_A]     <= w_d[4];
                        r_raw[BTN_START] <= w_d[5];
                    end
                    P2: begin
                        r_raw[BTN_UP]    <= w_d[0];
                        r_raw[BTN_DOWN]  <= w_d[1];
                        r_raw[BTN_LEFT]  <= w_d[2];
                        r_raw[BTN_RIGHT] <= w_d[3];
                        r_raw[BTN_B]     <= w_d[4];
                        r_raw[BTN_C]     <= w_d[5];
                    end
                    P5: r_six_flag <= &w_d[3:0];
                    P6: begin
                        if (r_six_flag) begin
                            r_raw[BTN_Z]    <= w_d[0];
                            r_raw[BTN_Y]    <= w_d[1];
                            r_raw[BTN_X]    <= w_d[2];
                            r_raw[BTN_MODE] <= w_d[3];
                        end
                    end
                    default: ;
                endcase
                if (r_state == P8) begin
                    r_state      <= IDLE;
                    r_select     <= 1'b1;
                    r_raw_done   <= w_raw_final;
                    r_six_button <= r_six_flag & r_present;
                    r_scan_done  <= 1'b1;
                end else begin
                    r_state  <= scan_state_t'(r_state + 4'd1);
                    r_select <= ~r_select;
                    r_step   <= STEP_LAST;
                end
            end
        end
    end

    genesis_pad_reader_debounce #(
        .WIDTH          (NUM_BTNS),
        .DEBOUNCE_POLLS (DEBOUNCE_POLLS)
    ) u_debounce (
        .clock_50    (clock_50),
        .reset_flag  (reset_flag),
        .raw         (r_raw_done),
        .strobe      (r_scan_done),
        .held        (w_held),
        .press_pulse (w_press)
    );

    assign pad_select     = r_select;
    assign control_inputs = w_press;
    assign buttons_held   = w_held;
    assign six_button     = r_six_button;
    assign scan_done      = r_scan_done;

endmodule

// File: tb/tb_genesis_pad_reader.sv
module tb_genesis_pad_reader;

    localparam int POLL_DIV = 64;
    localparam int STEP     = 4;
    localparam int DB       = 2;

    logic        clock_50   = 1'b0;
    logic        reset_flag = 1'b0;
    logic [5:0]  pad_data;
    logic        pad_select;
    logic [11:0] control_inputs;
    logic [11:0] buttons_held;
    logic        six_button;
    logic        scan_done;

    always #5 clock_50 = ~clock_50;

    genesis_pad_reader #(
        .POLL_DIV       (POLL_DIV),
        .STEP_CYCLES    (STEP),
        .DEBOUNCE_POLLS (DB)
    ) dut (
        .clock_50       (clock_50),
        .reset_flag     (reset_flag),
        .pad_data       (pad_data),
        .pad_select     (pad_select),
        .control_inputs (control_inputs),
        .buttons_held   (buttons_held),
        .six_button     (six_button),
        .scan_done      (scan_done)
    );

    // ---------------- pad model ----------------
    logic        m_present = 1'b0;
    logic        m_six     = 1'b0;
    logic        m_xforce  = 1'b0;
    logic [11:0] m_btn     = 12'h000;
    logic        prev_sel;
    int          fall_cnt;
    int          hi_cnt;

    always @(posedge clock_50 or posedge reset_flag) begin
        if (reset_flag) begin
            prev_sel <= 1'b1;
            fall_cnt <= 0;
            hi_cnt   <= 0;
        end else begin
            prev_sel <= pad_select;
            if (pad_select) begin
                if (hi_cnt < 15) hi_cnt <= hi_cnt + 1;
            end else begin
                hi_cnt <= 0;
            end
            if (hi_cnt > 8) fall_cnt <= 0;
            if (prev_sel && !pad_select) fall_cnt <= fall_cnt + 1;
        end
    end

    always_comb begin
        pad_data = 6'h3F;
        if (m_present) begin
            if (!pad_select) begin
                if (m_six && fall_cnt == 3)
                    pad_data = {~m_btn[10], ~m_btn[4], 4'b0000};
                else if (m_six && fall_cnt == 4)
                    pad_data = {~m_btn[10], ~m_btn[4], 4'b1111};
                else
                    pad_data = {~m_btn[10], ~m_btn[4], 2'b00, ~m_btn[1], ~m_btn[0]};
            end else begin
                if (m_six && fall_cnt == 3)
                    pad_data = {~m_btn[6], ~m_btn[5], ~m_btn[11], ~m_btn[7], ~m_btn[8], ~m_btn[9]};
                else begin
                    pad_data = {~m_btn[6], ~m_btn[5], ~m_btn[3], ~m_btn[2], ~m_btn[1], ~m_btn[0]};
                    if (m_xforce && fall_cnt == 3) pad_data[2] = 1'b0;
                end
            end
        end
    end

    // ---------------- vectors & scoreboard ----------------
    typedef struct packed {
        logic        p;
        logic        s;
        logic        x;
        logic [11:0] b;
        logic        es;
        logic [11:0] eh;
        logic [11:0] ep;
    } vec_t;

    typedef struct packed {
        logic        six;
        logic [11:0] held;
        logic [11:0] pulse;
    } exp_t;

    vec_t vt [0:23];
    exp_t sb_q [$];
    exp_t mon_e;

    int n_checks = 0;
    int n_pass   = 0;
    int stray    = 0;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %03h want %03h", name, act, req);
    endtask

    task automatic apply_push(input int i);
        exp_t e;
        m_present = vt[i].p;
        m_six     = vt[i].s;
        m_xforce  = vt[i].x;
        m_btn     = vt[i].b;
        e.six     = vt[i].es;
        e.held    = vt[i].eh;
        e.pulse   = vt[i].ep;
        sb_q.push_back(e);
    endtask

    task automatic wait_scan_done(input int i);
        int  cnt;
        bit  seen;
        cnt  = 0;
        seen = 0;
        while (!seen && cnt < 300) begin
            @(negedge clock_50);
            cnt++;
            if (scan_done) seen = 1;
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL scan_done_timeout: vector %0d got no scan_done in %0d clocks", i, cnt);
        end
    endtask

    task automatic measure_start(input string name);
        int cnt;
        bit seen;
        cnt  = 0;
        seen = 0;
        while (!seen && cnt < 200) begin
            @(posedge clock_50);
            cnt++;
            @(negedge clock_50);
            if (!pad_select) seen = 1;
        end
        n_checks++;
        if (seen && cnt == POLL_DIV) n_pass++;
        else $display("FAIL %s: select fell after %0d clocks (seen=%0d) want %0d", name, cnt, seen, POLL_DIV);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pad_select"},     {11'b0, pad_select}, 12'h001);
        check({tag, "_control_inputs"}, control_inputs,      12'h000);
        check({tag, "_buttons_held"},   buttons_held,        12'h000);
        check({tag, "_six_button"},     {11'b0, six_button}, 12'h000);
        check({tag, "_scan_done"},      {11'b0, scan_done},  12'h000);
    endtask

    logic mon_pending = 1'b0;
    logic mon_six     = 1'b0;

    always @(negedge clock_50) begin
        if (mon_pending) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL scoreboard_empty: scan completed with no expectation queued");
            end else begin
                mon_e = sb_q.pop_front();
                check("six_button",     {11'b0, mon_six}, {11'b0, mon_e.six});
                check("buttons_held",   buttons_held,     mon_e.held);
                check("control_inputs", control_inputs,   mon_e.pulse);
            end
        end else if (control_inputs != 12'h000) begin
            stray <= stray + 1;
        end
        mon_pending <= scan_done;
        if (scan_done) mon_six <= six_button;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        //            p     s     x     btn      es    held     pulse
        vt[0]  = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 12'h000};
        vt[1]  = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 12'h000};
        vt[2]  = '{1'b1, 1'b1, 1'b0, 12'h400, 1'b1, 12'h000, 12'h000};
        vt[3]  = '{1'b1, 1'b1, 1'b0, 12'h400, 1'b1, 12'h400, 12'h400};
        vt[4]  = '{1'b1, 1'b1, 1'b0, 12'h400, 1'b1, 12'h400, 12'h000};
        vt[5]  = '{1'b1, 1'b1, 1'b0, 12'h400, 1'b1, 12'h400, 12'h000};
        vt[6]  = '{1'b1, 1'b0, 1'b1, 12'h020, 1'b0, 12'h400, 12'h000};
        vt[7]  = '{1'b1, 1'b0, 1'b1, 12'h020, 1'b0, 12'h020, 12'h020};
        vt[8]  = '{1'b1, 1'b0, 1'b1, 12'h020, 1'b0, 12'h020, 12'h000};
        vt[9]  = '{1'b1, 1'b1, 1'b0, 12'h009, 1'b1, 12'h020, 12'h000};
        vt[10] = '{1'b1, 1'b1, 1'b0, 12'h009, 1'b1, 12'h009, 12'h009};
        vt[11] = '{1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 12'h009, 12'h000};
        vt[12] = '{1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 12'h000, 12'h000};
        vt[13] = '{1'b1, 1'b1, 1'b0, 12'h010, 1'b1, 12'h000, 12'h000};
        vt[14] = '{1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 12'h000, 12'h000};
        vt[15] = '{1'b1, 1'b1, 1'b0, 12'h010, 1'b1, 12'h000, 12'h000};
        vt[16] = '{1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 12'h000, 12'h000};
        vt[17] = '{1'b1, 1'b1, 1'b0, 12'h880, 1'b1, 12'h000, 12'h000};
        vt[18] = '{1'b1, 1'b1, 1'b0, 12'h880, 1'b1, 12'h880, 12'h880};
        vt[19] = '{1'b1, 1'b1, 1'b0, 12'h366, 1'b1, 12'h880, 12'h000};
        vt[20] = '{1'b1, 1'b1, 1'b0, 12'h366, 1'b1, 12'h366, 12'h366};
        vt[21] = '{1'b1, 1'b1, 1'b0, 12'h766, 1'b1, 12'h366, 12'h000};
        vt[22] = '{1'b1, 1'b1, 1'b0, 12'h400, 1'b1, 12'h000, 12'h000};
        vt[23] = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 12'h000};

        apply_push(0);
        #2 reset_flag = 1'b1;
        #1 check_reset_outputs("por");
        repeat (3) @(negedge clock_50);
        reset_flag = 1'b0;
        measure_start("first_scan_start");
        wait_scan_done(0);

        for (int i = 1; i <= 21; i++) begin
            apply_push(i);
            wait_scan_done(i);
        end

        // Abort the following scan part-way through P4.
        begin
            int cnt;
            cnt = 0;
            while (pad_select && cnt < 200) begin
                @(negedge clock_50);
                cnt++;
            end
            if (pad_select) begin
                n_checks++;
                $display("FAIL scan_start_timeout: select stayed high for %0d clocks", cnt);
            end
        end
        repeat (13) @(negedge clock_50);
        reset_flag = 1'b1;
        #1 check_reset_outputs("midscan");
        apply_push(22);
        repeat (3) @(negedge clock_50);
        reset_flag = 1'b0;
        measure_start("post_reset_scan_start");
        wait_scan_done(22);
        apply_push(23);
        wait_scan_done(23);
        repeat (4) @(negedge clock_50);

        check("queue_drained", 12'(sb_q.size()), 12'h000);
        check("stray_pulses",  12'(stray),       12'h000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
